// File: rtl/alu_4bit_issue_if.sv
// Command / ALU / response bundle for the 4-bit ALU issue front-end.
// The slave modport is the front-end's view; master is the surrounding
// environment (command producer, combinational ALU, response consumer).
interface alu_4bit_issue_if #(
  parameter int TAG_W = 4
);
  // command side
  logic             cmd_valid;
  logic             cmd_ready;
  logic [3:0]       cmd_a;
  logic [3:0]       cmd_b;
  logic [1:0]       cmd_op;
  logic [TAG_W-1:0] cmd_tag;

  // ALU side
  logic [3:0]       alu_a;
  logic [3:0]       alu_b;
  logic [1:0]       alu_sel;
  logic [3:0]       alu_result;
  logic             alu_zero;

  // response side
  logic             rsp_valid;
  logic             rsp_ready;
  logic [3:0]       rsp_result;
  logic             rsp_zero;
  logic             rsp_err;
  logic [TAG_W-1:0] rsp_tag;

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_op, cmd_tag,
    output cmd_ready,
    output alu_a, alu_b, alu_sel,
    input  alu_result, alu_zero,
    output rsp_valid, rsp_result, rsp_zero, rsp_err, rsp_tag,
    input  rsp_ready
  );

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_op, cmd_tag,
    input  cmd_ready,
    input  alu_a, alu_b, alu_sel,
    output alu_result, alu_zero,
    input  rsp_valid, rsp_result, rsp_zero, rsp_err, rsp_tag,
    output rsp_ready
  );
endinterface

// File: rtl/alu_4bit_issue.sv
// Issue front-end for a combinational 4-bit ALU: commands are queued in a
// small FIFO, the FIFO head drives the ALU, and the ALU outcome is captured
// into a tagged, back-pressurable response register.
module alu_4bit_issue #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  alu_4bit_issue_if.slave        bus,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic [7:0]             rsp_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [1:0] OP_RSVD = 2'b01;

  // FIFO storage, one field array per command component
  logic [3:0]       r_mem_a   [DEPTH];
  logic [3:0]       r_mem_b   [DEPTH];
  logic [1:0]       r_mem_op  [DEPTH];
  logic [TAG_W-1:0] r_mem_tag [DEPTH];

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;

  // response register
  logic             r_rsp_valid;
  logic [3:0]       r_rsp_result;
  logic             r_rsp_zero;
  logic             r_rsp_err;
  logic [TAG_W-1:0] r_rsp_tag;
  logic [7:0]       r_rsp_count;

  logic             w_empty;
  logic             w_full;
  logic             w_push;
  logic             w_fire;
  logic             w_handoff;
  logic [3:0]       w_head_a;
  logic [3:0]       w_head_b;
  logic [1:0]       w_head_op;
  logic [TAG_W-1:0] w_head_tag;
  logic             w_head_rsvd;

  assign w_empty   = (r_level == '0);
  assign w_full    = (r_level == LVL_W'(DEPTH));
  // Ready is a pure function of occupancy: a same-cycle pop never frees a
  // slot for the producer, which keeps cmd_ready off the response path.
  assign bus.cmd_ready = rst_n & ~w_full;
  assign w_push    = bus.cmd_valid & bus.cmd_ready;
  assign w_handoff = r_rsp_valid & bus.rsp_ready;
  assign w_fire    = ~w_empty & (~r_rsp_valid | bus.rsp_ready);

  assign w_head_a    = r_mem_a[r_rd_ptr];
  assign w_head_b    = r_mem_b[r_rd_ptr];
  assign w_head_op   = r_mem_op[r_rd_ptr];
  assign w_head_tag  = r_mem_tag[r_rd_ptr];
  assign w_head_rsvd = (w_head_op == OP_RSVD);

  // Present the FIFO head to the ALU; idle/reserved cases show a harmless add
  always_comb begin
    bus.alu_a   = 4'h0;
    bus.alu_b   = 4'h0;
    bus.alu_sel = 2'b00;
    if (!w_empty) begin
      bus.alu_a   = w_head_a;
      bus.alu_b   = w_head_b;
      bus.alu_sel = w_head_rsvd ? 2'b00 : w_head_op;
    end
  end

  // Write accepted commands into the FIFO (data needs no reset)
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_a[r_wr_ptr]   <= bus.cmd_a;
      r_mem_b[r_wr_ptr]   <= bus.cmd_b;
      r_mem_op[r_wr_ptr]  <= bus.cmd_op;
      r_mem_tag[r_wr_ptr] <= bus.cmd_tag;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally as DEPTH is 2^n
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_fire) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_fire})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Capture the ALU outcome for the head when the response slot is free
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rsp_valid  <= 1'b0;
      r_rsp_result <= 4'h0;
      r_rsp_zero   <= 1'b0;
      r_rsp_err    <= 1'b0;
      r_rsp_tag    <= '0;
    end else if (w_fire) begin
      r_rsp_valid  <= 1'b1;
      r_rsp_tag    <= w_head_tag;
      r_rsp_err    <= w_head_rsvd;
      r_rsp_result <= w_head_rsvd ? 4'h0 : bus.alu_result;
      r_rsp_zero   <= w_head_rsvd ? 1'b0 : bus.alu_zero;
    end else if (w_handoff) begin
      r_rsp_valid  <= 1'b0;
    end
  end

  // Count completed handoffs, wrapping at 8 bits
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rsp_count <= 8'h00;
    end else if (w_handoff) begin
      r_rsp_count <= r_rsp_count + 8'h01;
    end
  end

  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_result = r_rsp_result;
  assign bus.rsp_zero   = r_rsp_zero;
  assign bus.rsp_err    = r_rsp_err;
  assign bus.rsp_tag    = r_rsp_tag;
  assign fifo_level     = r_level;
  assign rsp_count      = r_rsp_count;

endmodule

// File: tb/tb_alu_4bit_issue.sv
// Directed bench for the ALU issue front-end; the bench also plays the ALU.
module tb_alu_4bit_issue;

  logic       clk;
  logic       rst_n;
  logic [2:0] fifo_level;
  logic [7:0] rsp_count;

  int total = 0;
  int fails = 0;

  alu_4bit_issue_if #(.TAG_W(4)) bus ();

  alu_4bit_issue #(.DEPTH(4), .TAG_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .fifo_level (fifo_level),
    .rsp_count  (rsp_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational ALU model
  always_comb begin
    case (bus.alu_sel)
      2'b00:   bus.alu_result = bus.alu_a + bus.alu_b;
      2'b10:   bus.alu_result = bus.alu_a & bus.alu_b;
      2'b11:   bus.alu_result = bus.alu_a | bus.alu_b;
      default: bus.alu_result = 4'h0;
    endcase
    bus.alu_zero = (bus.alu_result == 4'h0);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected response {result, zero, err, tag} from the ALU definition
  function automatic logic [9:0] model(input logic [3:0] a, input logic [3:0] b,
                                       input logic [1:0] op, input logic [3:0] tag);
    logic [3:0] r;
    case (op)
      2'b00:   r = a + b;
      2'b10:   r = a & b;
      2'b11:   r = a | b;
      default: r = 4'h0;
    endcase
    if (op == 2'b01) return {4'h0, 1'b0, 1'b1, tag};
    return {r, (r == 4'h0), 1'b0, tag};
  endfunction

  // Push one command with rsp_ready high and check its response two edges later
  task automatic send_check(input string name, input logic [3:0] a, input logic [3:0] b,
                            input logic [1:0] op, input logic [3:0] tag,
                            input logic [3:0] er, input logic ez, input logic ee);
    bus.cmd_valid = 1'b1;
    bus.cmd_a = a; bus.cmd_b = b; bus.cmd_op = op; bus.cmd_tag = tag;
    step();
    bus.cmd_valid = 1'b0;
    check({name, "_pending"}, bus.rsp_valid, 0);
    check({name, "_level"}, fifo_level, 1);
    check({name, "_alu_a"}, bus.alu_a, a);
    check({name, "_alu_sel"}, bus.alu_sel, (op == 2'b01) ? 2'b00 : op);
    step();
    check({name, "_valid"}, bus.rsp_valid, 1);
    check({name, "_result"}, bus.rsp_result, er);
    check({name, "_zero"}, bus.rsp_zero, ez);
    check({name, "_err"}, bus.rsp_err, ee);
    check({name, "_tag"}, bus.rsp_tag, tag);
    step();
    check({name, "_cleared"}, bus.rsp_valid, 0);
  endtask

  initial begin
    logic [9:0] q[$];
    logic [9:0] exp_rsp;
    int sent;
    int got;
    int cyc;

    rst_n = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_a = 4'h0; bus.cmd_b = 4'h0; bus.cmd_op = 2'b00; bus.cmd_tag = 4'h0;
    bus.rsp_ready = 1'b1;

    // Reset state
    step(); step();
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_level", fifo_level, 0);
    check("rst_count", rsp_count, 0);
    check("rst_result", bus.rsp_result, 0);
    check("rst_tag", bus.rsp_tag, 0);
    check("rst_cmd_ready", bus.cmd_ready, 0);
    check("rst_alu_sel", bus.alu_sel, 0);
    check("rst_alu_a", bus.alu_a, 0);
    rst_n = 1'b1;
    step();
    check("rel_cmd_ready", bus.cmd_ready, 1);

    // Directed single commands
    send_check("add", 4'h3, 4'h4, 2'b00, 4'd1, 4'h7, 1'b0, 1'b0);
    check("count_1", rsp_count, 1);
    send_check("wrap", 4'hF, 4'h1, 2'b00, 4'd2, 4'h0, 1'b1, 1'b0);
    send_check("and", 4'hA, 4'h5, 2'b10, 4'd3, 4'h0, 1'b1, 1'b0);
    send_check("or", 4'hA, 4'h5, 2'b11, 4'd4, 4'hF, 1'b0, 1'b0);
    send_check("rsvd", 4'h5, 4'h2, 2'b01, 4'd7, 4'h0, 1'b0, 1'b1);
    check("count_5", rsp_count, 5);

    // Back-pressure: 6 pushes, only 5 fit (1 in rsp reg + 4 queued)
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.cmd_valid = 1'b1;
      bus.cmd_a = 4'(i); bus.cmd_b = 4'h1; bus.cmd_op = 2'b00; bus.cmd_tag = 4'(8 + i);
      step();
    end
    bus.cmd_valid = 1'b0;
    check("bp_level", fifo_level, 4);
    check("bp_cmd_ready", bus.cmd_ready, 0);
    check("bp_hold_valid", bus.rsp_valid, 1);
    check("bp_hold_tag", bus.rsp_tag, 8);
    check("bp_hold_result", bus.rsp_result, 1);
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check("bp_drain_valid", bus.rsp_valid, 1);
      check("bp_drain_tag", bus.rsp_tag, 8 + k);
      check("bp_drain_result", bus.rsp_result, k + 1);
      step();
    end
    check("bp_done_valid", bus.rsp_valid, 0);
    check("bp_done_level", fifo_level, 0);
    check("bp_count", rsp_count, 10);

    // Reset mid-stream
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.cmd_valid = 1'b1;
      bus.cmd_a = 4'h2; bus.cmd_b = 4'h2; bus.cmd_op = 2'b00; bus.cmd_tag = 4'(1 + i);
      step();
    end
    bus.cmd_valid = 1'b0;
    check("mid_level", fifo_level, 3);
    check("mid_valid", bus.rsp_valid, 1);
    rst_n = 1'b0;
    step();
    check("mid_rst_valid", bus.rsp_valid, 0);
    check("mid_rst_level", fifo_level, 0);
    check("mid_rst_count", rsp_count, 0);
    check("mid_rst_ready", bus.cmd_ready, 0);
    rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    step();
    check("mid_rel_ready", bus.cmd_ready, 1);
    step();
    check("mid_no_stale", bus.rsp_valid, 0);
    check("mid_no_stale_level", fifo_level, 0);

    // Random streaming against the reference model
    sent = 0; got = 0; cyc = 0;
    while ((sent < 300 || got < 300) && cyc < 5000) begin
      bus.cmd_valid = (sent < 300) && ($urandom_range(0, 3) != 0);
      bus.cmd_a   = 4'($urandom_range(0, 15));
      bus.cmd_b   = 4'($urandom_range(0, 15));
      bus.cmd_op  = 2'($urandom_range(0, 3));
      bus.cmd_tag = 4'($urandom_range(0, 15));
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      if (bus.cmd_valid && bus.cmd_ready) begin
        q.push_back(model(bus.cmd_a, bus.cmd_b, bus.cmd_op, bus.cmd_tag));
        sent++;
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        exp_rsp = (q.size() != 0) ? q.pop_front() : 10'h3FF;
        check("stream_rsp", {bus.rsp_result, bus.rsp_zero, bus.rsp_err, bus.rsp_tag}, exp_rsp);
        got++;
      end
      step();
      cyc++;
    end
    bus.cmd_valid = 1'b0;
    check("stream_done", got, 300);
    check("stream_count", rsp_count, 44);
    check("stream_empty", fifo_level, 0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule

// File: doc/alu_4bit_issue.md
Name: alu_4bit_issue

Overview:
- Command front-end that sits directly upstream of the 4-bit ALU: buffers operand/op-code commands in a small FIFO, drives the ALU ports from the FIFO head, and registers the ALU result and zero flag into a tagged response with valid/ready handshake.
- Decouples bursty command producers from the combinational ALU and gives the ALU a registered, back-pressurable output.

Parameters:
- DEPTH, 4, command FIFO entries; power of two, >= 2.
- TAG_W, 4, width of the command/response tag.

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  FIFO can accept; equals (level < DEPTH).
- cmd_a  input  4  operand A.
- cmd_b  input  4  operand B.
- cmd_op  input  2  00 add, 01 reserved, 10 AND, 11 OR.
- cmd_tag  input  TAG_W  opaque tag returned with response.
- alu_a  output  4  to ALU A.
- alu_b  output  4  to ALU B.
- alu_sel  output  2  to ALU op-code.
- alu_result  input  4  from ALU Result (combinational).
- alu_zero  input  1  from ALU Zero flag.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts response.
- rsp_result  output  4  captured result.
- rsp_zero  output  1  captured zero flag.
- rsp_err  output  1  1 = reserved op-code, result not computed.
- rsp_tag  output  TAG_W  tag of the command.
- fifo_level  output  clog2(DEPTH)+1  current FIFO occupancy.
- rsp_count  output  8  responses handed off (rsp_valid & rsp_ready), wraps 255->0.

Behaviour:
- Reset (rst_n=0 at edge): FIFO emptied (pointers and level 0), rsp_valid=0, rsp_result=0, rsp_zero=0, rsp_err=0, rsp_tag=0, rsp_count=0. In-flight commands are discarded, not completed. cmd_ready is 0 while rst_n is low and returns to 1 the cycle after release.
- Push: cmd_valid & cmd_ready at edge writes {a,b,op,tag} at wr_ptr. No bypass; an entry is visible at the head no earlier than the next cycle.
- Head drive: when the FIFO is non-empty, alu_a/alu_b/alu_sel = head fields combinationally. When empty, they are 0/0/00. For a reserved head op (01), alu_sel is 00.
- Issue: fire = non-empty & (!rsp_valid | rsp_ready). On fire at the edge:
  - Pop the head.
  - Load rsp_result = alu_result and rsp_zero = alu_zero (for err=0).
  - For op 01: rsp_result=0, rsp_zero=0, rsp_err=1.
  - Set rsp_tag from the head and rsp_valid=1.
- Hold: if rsp_valid & !rsp_ready, all rsp_* hold stable and the head is not popped.
- If rsp_valid & rsp_ready and the FIFO is empty, rsp_valid clears.
- Latency: push in cycle N gives rsp_valid in cycle N+2 minimum. Throughput is 1 response/cycle with rsp_ready held high.
- Ordering: responses are strictly in command order.
- Simultaneous push and pop: level unchanged, both operations take effect.
- Full: cmd_ready=0 when level==DEPTH, even if a pop occurs the same cycle (no pass-through).
- Pointer wrap: pointers are modulo DEPTH. Level is a separate counter, 0..DEPTH.
- rsp_count increments on every rsp_valid & rsp_ready edge.

Test Plan:
- Reset mid-stream: 3 commands queued and rsp_valid=1 held by rsp_ready=0, then rst_n low one cycle -> rsp_valid=0, fifo_level=0, rsp_count=0; no stale response after release.
- Single add: push a=4'h3, b=4'h4, op=00, tag=1 at cycle N, rsp_ready=1 -> at N+2: rsp_valid=1, result=4'h7, zero=0, err=0, tag=1.
- Wrap and zero flag: push a=4'hF, b=4'h1, op=00 -> result=4'h0, zero=1. Push a=4'hA, b=4'h5, op=10 -> result=0, zero=1. Push the same with op=11 -> result=4'hF, zero=0.
- Reserved op: push op=01, a=5, b=2, tag=7 -> rsp_err=1, result=0, zero=0, tag=7; alu_sel observed 00 while that entry is at head.
- Back-pressure/full: rsp_ready=0, push 6 commands back-to-back -> first completes into rsp reg, fifo_level reaches 4, cmd_ready=0. Then raise rsp_ready -> all 5 accepted commands return in order, one per cycle, with correct tags.
- Streaming: 300 random commands, random cmd_valid and rsp_ready -> every response matches a reference model in order; rsp_count = 300 mod 256 = 44.
